// File: rtl/slave_rd_arbiter_pkg.sv
// Widths, order-FIFO entry type and round-robin search for the slave read arbiter.
package slave_rd_arb_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_LEN_WIDTH  = 8;
    localparam int AXI_SIZE_WIDTH = 3;
    localparam int WORD_SIZE      = 64;

    // Requester ids are sized for the largest supported requester count.
    localparam int MAX_REQ  = 8;
    localparam int ID_WIDTH = $clog2(MAX_REQ);

    typedef logic [ID_WIDTH-1:0]      req_id_t;
    typedef logic [AXI_LEN_WIDTH-1:0] axi_len_t;

    typedef struct packed {
        req_id_t  id;
        axi_len_t len;
    } ord_entry_t;

    // First set request after 'last', wrapping modulo num_req.
    function automatic req_id_t RR_NEXT(
        input logic [MAX_REQ-1:0] req,
        input req_id_t            last,
        input int                 num_req
    );
        req_id_t win;
        logic    found;
        int      cand;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            cand = int'(last) + k;
            if (cand >= num_req) cand = cand - num_req;
            if (k <= num_req && !found && req[cand[ID_WIDTH-1:0]]) begin
                win   = cand[ID_WIDTH-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/slave_rd_arbiter_if.sv
// Requester, memory-queue and response signals shared by the slave read arbiter.
interface slave_rd_arbiter_if
    import slave_rd_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]                req_cmd_rd;
    logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*AXI_LEN_WIDTH-1:0]  req_len;
    logic [NUM_REQ*AXI_SIZE_WIDTH-1:0] req_size;
    logic [NUM_REQ-1:0]                req_ack;

    logic                      slave2mem_cmd_rd;
    logic [AXI_ADDR_WIDTH-1:0] slave2mem_addr;
    logic [AXI_LEN_WIDTH-1:0]  slave2mem_len;
    logic [AXI_SIZE_WIDTH-1:0] slave2mem_size;
    logic                      mem2slave_rd_ready;
    logic                      mem2slave_rdresp_vld;
    logic [WORD_SIZE-1:0]      mem2slave_rdresp_data;

    logic [NUM_REQ-1:0]        rsp_vld;
    logic [WORD_SIZE-1:0]      rsp_data;
    logic                      rsp_last;
    logic                      err_orphan;

    modport slave (
        input  req_cmd_rd, req_addr, req_len, req_size,
               mem2slave_rd_ready, mem2slave_rdresp_vld, mem2slave_rdresp_data,
        output req_ack, slave2mem_cmd_rd, slave2mem_addr, slave2mem_len, slave2mem_size,
               rsp_vld, rsp_data, rsp_last, err_orphan
    );

    modport master (
        output req_cmd_rd, req_addr, req_len, req_size,
               mem2slave_rd_ready, mem2slave_rdresp_vld, mem2slave_rdresp_data,
        input  req_ack, slave2mem_cmd_rd, slave2mem_addr, slave2mem_len, slave2mem_size,
               rsp_vld, rsp_data, rsp_last, err_orphan
    );

endinterface

// File: rtl/slave_rd_arbiter_ord_fifo.sv
// Order FIFO: remembers which requester owns each outstanding command, in issue order.
module slave_rd_ord_fifo
    import slave_rd_arb_pkg::*;
#(
    parameter int DEPTH = 8
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  ord_entry_t push_entry_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output ord_entry_t head_o
);
    localparam int PTR_W = $clog2(DEPTH);

    ord_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    // Full is judged on the pre-pop count, so a pop never makes room in the same cycle.
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // NOTE: storage is left unreset; only pointers and count decide validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
    end

    // NOTE: sequential state uses <= so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/slave_rd_arbiter.sv
// Round-robin issue of requester read commands into one memory read port, with
// in-order routing of returned beats back to their owners.
module slave_rd_arbiter
    import slave_rd_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ORD_DEPTH = 8,
    parameter int ISSUE_GAP = 2
)(
    input logic               clk,
    input logic               reset,
    slave_rd_arbiter_if.slave bus
);
    localparam int              GAP_W    = $clog2(ISSUE_GAP);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(ISSUE_GAP - 1);

    logic [NUM_REQ-1:0]        eligible;
    logic [MAX_REQ-1:0]        eligible_ext;
    req_id_t                   winner;
    logic                      issue;

    req_id_t                   last_grant_q, last_grant_d;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic                      cmd_q, cmd_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    axi_len_t                  len_q, len_d;
    logic [AXI_SIZE_WIDTH-1:0] size_q, size_d;
    logic [NUM_REQ-1:0]        ack_q, ack_d;

    axi_len_t                  beat_q, beat_d;
    logic [NUM_REQ-1:0]        rsp_vld_q, rsp_vld_d;
    logic [WORD_SIZE-1:0]      rsp_data_q, rsp_data_d;
    logic                      rsp_last_q, rsp_last_d;
    logic                      orphan_q, orphan_d;

    ord_entry_t                push_entry, head;
    logic                      fifo_full, fifo_empty, fifo_pop;

    slave_rd_ord_fifo #(.DEPTH(ORD_DEPTH)) u_ord_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (issue),
        .push_entry_i (push_entry),
        .pop_i        (fifo_pop),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .head_o       (head)
    );

    // A requester whose ack is high is still showing its old, already-taken command.
    always_comb begin
        eligible     = bus.req_cmd_rd & ~ack_q;
        eligible_ext = '0;
        eligible_ext[NUM_REQ-1:0] = eligible;
        winner       = RR_NEXT(eligible_ext, last_grant_q, NUM_REQ);
        issue        = (|eligible) && bus.mem2slave_rd_ready && !fifo_full && (gap_q == '0);
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        cmd_d        = issue;
        ack_d        = '0;
        addr_d       = addr_q;
        len_d        = len_q;
        size_d       = size_q;
        last_grant_d = last_grant_q;
        push_entry   = '0;
        gap_d        = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
        if (issue) begin
            ack_d          = NUM_REQ'(1) << winner;
            addr_d         = bus.req_addr[int'(winner)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            len_d          = bus.req_len[int'(winner)*AXI_LEN_WIDTH +: AXI_LEN_WIDTH];
            size_d         = bus.req_size[int'(winner)*AXI_SIZE_WIDTH +: AXI_SIZE_WIDTH];
            last_grant_d   = winner;
            push_entry.id  = winner;
            push_entry.len = bus.req_len[int'(winner)*AXI_LEN_WIDTH +: AXI_LEN_WIDTH];
            gap_d          = GAP_LOAD;
        end
    end

    // Beats go to the oldest outstanding command; a beat with nothing outstanding is dropped.
    always_comb begin
        rsp_vld_d  = '0;
        rsp_last_d = 1'b0;
        rsp_data_d = rsp_data_q;
        beat_d     = beat_q;
        orphan_d   = orphan_q;
        fifo_pop   = 1'b0;
        if (bus.mem2slave_rdresp_vld) begin
            if (fifo_empty) begin
                orphan_d = 1'b1;
            end else begin
                rsp_vld_d  = NUM_REQ'(1) << head.id;
                rsp_data_d = bus.mem2slave_rdresp_data;
                if (beat_q == head.len) begin
                    rsp_last_d = 1'b1;
                    fifo_pop   = 1'b1;
                    beat_d     = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= req_id_t'(NUM_REQ - 1);
            gap_q        <= '0;
            cmd_q        <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            ack_q        <= '0;
            beat_q       <= '0;
            rsp_vld_q    <= '0;
            rsp_data_q   <= '0;
            rsp_last_q   <= 1'b0;
            orphan_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            gap_q        <= gap_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            size_q       <= size_d;
            ack_q        <= ack_d;
            beat_q       <= beat_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_data_q   <= rsp_data_d;
            rsp_last_q   <= rsp_last_d;
            orphan_q     <= orphan_d;
        end
    end

    assign bus.slave2mem_cmd_rd = cmd_q;
    assign bus.slave2mem_addr   = addr_q;
    assign bus.slave2mem_len    = len_q;
    assign bus.slave2mem_size   = size_q;
    assign bus.req_ack          = ack_q;
    assign bus.rsp_vld          = rsp_vld_q;
    assign bus.rsp_data         = rsp_data_q;
    assign bus.rsp_last         = rsp_last_q;
    assign bus.err_orphan       = orphan_q;

endmodule

// File: tb/tb_slave_rd_arbiter.sv
// Bench for slave_rd_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model of issue order and beat ownership.
module tb_slave_rd_arbiter;
    import slave_rd_arb_pkg::*;

    localparam int NR    = 2;
    localparam int DEPTH = 8;
    localparam int GAP   = 2;

    typedef struct { int id; int len; } cmd_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    slave_rd_arbiter_if #(.NUM_REQ(NR)) bus ();

    slave_rd_arbiter #(.NUM_REQ(NR), .ORD_DEPTH(DEPTH), .ISSUE_GAP(GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Requester-side stimulus state
    logic                      r_req  [NR];
    logic [AXI_ADDR_WIDTH-1:0] r_addr [NR];
    axi_len_t                  r_len  [NR];
    logic [AXI_SIZE_WIDTH-1:0] r_size [NR];
    int on_ack;   // 0 drop, 1 replace, 2 keep same, 3 random drop/replace
    int len_max;

    // Reference model
    cmd_t          m_q[$];
    int            m_last, m_since, m_beat;
    bit            m_orphan;
    logic [NR-1:0] m_ackv;

    // Observed DUT activity for directed scenarios
    int grant_log[$];
    int strobe_cyc[$];
    int rsp_id_log[$];
    int last_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            bus.req_cmd_rd[i] = r_req[i];
            bus.req_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH] = r_addr[i];
            bus.req_len[i*AXI_LEN_WIDTH +: AXI_LEN_WIDTH]    = r_len[i];
            bus.req_size[i*AXI_SIZE_WIDTH +: AXI_SIZE_WIDTH] = r_size[i];
        end
    endtask

    task automatic new_cmd(input int i);
        r_req[i]  = 1'b1;
        r_addr[i] = $urandom;
        r_len[i]  = axi_len_t'($urandom_range(0, len_max));
        r_size[i] = AXI_SIZE_WIDTH'($urandom_range(0, 3));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last   = NR - 1;
        m_since  = GAP;
        m_beat   = 0;
        m_orphan = 1'b0;
        m_ackv   = '0;
        grant_log.delete();
        strobe_cyc.delete();
        rsp_id_log.delete();
        last_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.mem2slave_rd_ready    = 1'b0;
        bus.mem2slave_rdresp_vld  = 1'b0;
        bus.mem2slave_rdresp_data = '0;
        for (int i = 0; i < NR; i++) begin
            r_req[i]  = 1'b0;
            r_addr[i] = '0;
            r_len[i]  = '0;
            r_size[i] = '0;
        end
        drive_reqs();
        on_ack  = 0;
        len_max = 3;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    // One clock: predict from the model, let the edge happen, compare, advance the model.
    task automatic tick();
        logic [NR-1:0]             elig, e_ack, e_rv;
        logic [AXI_ADDR_WIDTH-1:0] e_addr;
        axi_len_t                  e_len;
        logic [AXI_SIZE_WIDTH-1:0] e_size;
        logic [WORD_SIZE-1:0]      e_data;
        bit                        iss, dlv, e_last;
        int                        w, idx;

        drive_reqs();
        elig = '0;
        for (int i = 0; i < NR; i++) elig[i] = r_req[i] && !m_ackv[i];
        iss = (elig != '0) && bus.mem2slave_rd_ready && (m_q.size() < DEPTH) && (m_since >= GAP);
        w = -1;
        if (iss) begin
            for (int k = 1; k <= NR; k++) begin
                idx = (m_last + k) % NR;
                if (w < 0 && elig[idx]) w = idx;
            end
        end
        e_ack = '0;
        e_addr = '0; e_len = '0; e_size = '0;
        if (iss) begin
            e_ack[w] = 1'b1;
            e_addr   = r_addr[w];
            e_len    = r_len[w];
            e_size   = r_size[w];
        end

        e_rv = '0; e_last = 1'b0; dlv = 1'b0; e_data = '0;
        if (bus.mem2slave_rdresp_vld) begin
            if (m_q.size() == 0) begin
                m_orphan = 1'b1;
            end else begin
                dlv = 1'b1;
                e_rv[m_q[0].id] = 1'b1;
                e_data = bus.mem2slave_rdresp_data;
                e_last = (m_beat == m_q[0].len);
            end
        end

        @(posedge clk);
        #1;
        cyc++;

        checks++;
        if (bus.slave2mem_cmd_rd !== iss) begin
            errors++;
            $display("FAIL strobe cyc=%0d got=%b exp=%b", cyc, bus.slave2mem_cmd_rd, iss);
        end
        checks++;
        if (bus.req_ack !== e_ack) begin
            errors++;
            $display("FAIL req_ack cyc=%0d got=%b exp=%b", cyc, bus.req_ack, e_ack);
        end
        if (iss) begin
            checks++;
            if ({bus.slave2mem_addr, bus.slave2mem_len, bus.slave2mem_size} !== {e_addr, e_len, e_size}) begin
                errors++;
                $display("FAIL cmd_fields cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, bus.slave2mem_addr,
                         bus.slave2mem_len, bus.slave2mem_size, e_addr, e_len, e_size);
            end
        end
        checks++;
        if (bus.rsp_vld !== e_rv) begin
            errors++;
            $display("FAIL rsp_vld cyc=%0d got=%b exp=%b", cyc, bus.rsp_vld, e_rv);
        end
        checks++;
        if (bus.rsp_last !== e_last) begin
            errors++;
            $display("FAIL rsp_last cyc=%0d got=%b exp=%b", cyc, bus.rsp_last, e_last);
        end
        if (dlv) begin
            checks++;
            if (bus.rsp_data !== e_data) begin
                errors++;
                $display("FAIL rsp_data cyc=%0d got=%h exp=%h", cyc, bus.rsp_data, e_data);
            end
        end
        checks++;
        if (bus.err_orphan !== m_orphan) begin
            errors++;
            $display("FAIL err_orphan cyc=%0d got=%b exp=%b", cyc, bus.err_orphan, m_orphan);
        end

        for (int i = 0; i < NR; i++) begin
            if (bus.req_ack[i] === 1'b1) grant_log.push_back(i);
            if (bus.rsp_vld[i] === 1'b1) rsp_id_log.push_back(i);
        end
        if (bus.slave2mem_cmd_rd === 1'b1) strobe_cyc.push_back(cyc);
        if (bus.rsp_last === 1'b1) last_cnt++;

        if (dlv) begin
            if (e_last) begin
                m_q.delete(0);
                m_beat = 0;
            end else begin
                m_beat++;
            end
        end
        if (iss) begin
            m_q.push_back('{w, int'(r_len[w])});
            m_last  = w;
            m_since = 1;
            case (on_ack)
                0: r_req[w] = 1'b0;
                1: new_cmd(w);
                3: if ($urandom_range(0, 1) == 0) r_req[w] = 1'b0; else new_cmd(w);
                default: ;
            endcase
        end else begin
            m_since++;
        end
        m_ackv = e_ack;
        drive_reqs();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.slave2mem_cmd_rd !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%b exp=0", bus.slave2mem_cmd_rd); end
        checks++; if (bus.slave2mem_addr !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", bus.slave2mem_addr); end
        checks++; if (bus.slave2mem_len !== '0) begin errors++; $display("FAIL reset_len got=%h exp=0", bus.slave2mem_len); end
        checks++; if (bus.slave2mem_size !== '0) begin errors++; $display("FAIL reset_size got=%h exp=0", bus.slave2mem_size); end
        checks++; if (bus.req_ack !== '0) begin errors++; $display("FAIL reset_ack got=%b exp=0", bus.req_ack); end
        checks++; if (bus.rsp_vld !== '0) begin errors++; $display("FAIL reset_rsp_vld got=%b exp=0", bus.rsp_vld); end
        checks++; if (bus.rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); end
        checks++; if (bus.rsp_last !== 1'b0) begin errors++; $display("FAIL reset_rsp_last got=%b exp=0", bus.rsp_last); end
        checks++; if (bus.err_orphan !== 1'b0) begin errors++; $display("FAIL reset_orphan got=%b exp=0", bus.err_orphan); end
        repeat (3) tick();
    endtask

    task automatic test_single();
        logic [WORD_SIZE-1:0] d [4];
        do_reset();
        on_ack    = 0;
        r_req[0]  = 1'b1;
        r_addr[0] = 32'h1000;
        r_len[0]  = 8'd3;
        r_size[0] = 3'd2;
        bus.mem2slave_rd_ready = 1'b1;
        repeat (4) tick();
        for (int b = 0; b < 4; b++) begin
            d[b] = {$urandom, $urandom};
            bus.mem2slave_rdresp_vld  = 1'b1;
            bus.mem2slave_rdresp_data = d[b];
            tick();
        end
        bus.mem2slave_rdresp_vld = 1'b0;
        repeat (2) tick();
        checks++;
        if (strobe_cyc.size() != 1 || grant_log.size() != 1 || grant_log[0] != 0) begin
            errors++;
            $display("FAIL single_grant strobes=%0d grants=%0d exp=1 strobe to req0", strobe_cyc.size(), grant_log.size());
        end
        checks++;
        if (rsp_id_log.size() != 4 || last_cnt != 1) begin
            errors++;
            $display("FAIL single_beats got beats=%0d lasts=%0d exp=4/1", rsp_id_log.size(), last_cnt);
        end
    endtask

    task automatic test_contention();
        do_reset();
        on_ack = 2;
        new_cmd(0);
        new_cmd(1);
        bus.mem2slave_rd_ready = 1'b1;
        repeat (8) tick();
        checks++;
        if (grant_log.size() != 4) begin
            errors++;
            $display("FAIL contention_count got=%0d exp=4", grant_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grant_log[i] != i % 2) begin
                    errors++;
                    $display("FAIL contention_order idx=%0d got=%0d exp=%0d", i, grant_log[i], i % 2);
                end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (strobe_cyc[i] - strobe_cyc[i-1] != GAP) begin
                    errors++;
                    $display("FAIL contention_spacing idx=%0d got=%0d exp=%0d", i, strobe_cyc[i] - strobe_cyc[i-1], GAP);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        on_ack = 0;
        new_cmd(1);
        bus.mem2slave_rd_ready = 1'b0;
        repeat (10) tick();
        checks++;
        if (strobe_cyc.size() != 0) begin
            errors++;
            $display("FAIL backpressure_hold got strobes=%0d exp=0", strobe_cyc.size());
        end
        bus.mem2slave_rd_ready = 1'b1;
        tick();
        checks++;
        if (bus.slave2mem_cmd_rd !== 1'b1 || bus.req_ack !== 2'b10) begin
            errors++;
            $display("FAIL backpressure_release got strobe=%b ack=%b exp=1/10", bus.slave2mem_cmd_rd, bus.req_ack);
        end
    endtask

    task automatic test_full_fifo();
        int vcyc;
        do_reset();
        on_ack  = 1;
        len_max = 0;
        new_cmd(0);
        new_cmd(1);
        bus.mem2slave_rd_ready = 1'b1;
        repeat (20) tick();
        checks++;
        if (strobe_cyc.size() != DEPTH) begin
            errors++;
            $display("FAIL full_withhold got strobes=%0d exp=%0d", strobe_cyc.size(), DEPTH);
        end
        bus.mem2slave_rdresp_vld  = 1'b1;
        bus.mem2slave_rdresp_data = {$urandom, $urandom};
        tick();
        vcyc = cyc;
        bus.mem2slave_rdresp_vld = 1'b0;
        on_ack = 0;
        tick();
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        tick();
        checks++;
        if (strobe_cyc.size() != DEPTH + 1 || strobe_cyc[DEPTH] != vcyc + 1) begin
            errors++;
            $display("FAIL full_release got strobes=%0d exp=%0d one cycle after pop", strobe_cyc.size(), DEPTH + 1);
        end
        bus.mem2slave_rdresp_vld = 1'b1;
        for (int b = 0; b < DEPTH; b++) begin
            bus.mem2slave_rdresp_data = {$urandom, $urandom};
            tick();
        end
        bus.mem2slave_rdresp_vld = 1'b0;
        tick();
        checks++;
        if (rsp_id_log.size() != DEPTH + 1) begin
            errors++;
            $display("FAIL full_drain got beats=%0d exp=%0d", rsp_id_log.size(), DEPTH + 1);
        end else begin
            for (int i = 0; i <= DEPTH; i++) begin
                checks++;
                if (rsp_id_log[i] != i % 2) begin
                    errors++;
                    $display("FAIL full_rsp_order idx=%0d got=%0d exp=%0d", i, rsp_id_log[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_orphan();
        do_reset();
        bus.mem2slave_rdresp_vld  = 1'b1;
        bus.mem2slave_rdresp_data = {$urandom, $urandom};
        tick();
        bus.mem2slave_rdresp_vld = 1'b0;
        checks++;
        if (bus.err_orphan !== 1'b1 || bus.rsp_vld !== '0) begin
            errors++;
            $display("FAIL orphan_flag got orphan=%b rsp_vld=%b exp=1/00", bus.err_orphan, bus.rsp_vld);
        end
        repeat (5) tick();
        checks++;
        if (bus.err_orphan !== 1'b1) begin
            errors++;
            $display("FAIL orphan_sticky got=%b exp=1", bus.err_orphan);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        on_ack    = 0;
        r_req[0]  = 1'b1;
        r_addr[0] = $urandom;
        r_len[0]  = 8'd3;
        r_size[0] = 3'd3;
        bus.mem2slave_rd_ready = 1'b1;
        repeat (2) tick();
        bus.mem2slave_rdresp_vld = 1'b1;
        repeat (2) begin
            bus.mem2slave_rdresp_data = {$urandom, $urandom};
            tick();
        end
        bus.mem2slave_rdresp_vld = 1'b0;
        reset = 1'b0;
        #2;
        checks++;
        if ({bus.slave2mem_cmd_rd, bus.req_ack, bus.rsp_vld, bus.rsp_last, bus.err_orphan} !== '0) begin
            errors++;
            $display("FAIL midreset_ctrl got strobe=%b ack=%b vld=%b last=%b orphan=%b exp=all 0",
                     bus.slave2mem_cmd_rd, bus.req_ack, bus.rsp_vld, bus.rsp_last, bus.err_orphan);
        end
        checks++;
        if ({bus.slave2mem_addr, bus.slave2mem_len, bus.slave2mem_size, bus.rsp_data} !== '0) begin
            errors++;
            $display("FAIL midreset_data got addr=%h len=%h size=%h data=%h exp=all 0",
                     bus.slave2mem_addr, bus.slave2mem_len, bus.slave2mem_size, bus.rsp_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        bus.mem2slave_rdresp_vld  = 1'b1;
        bus.mem2slave_rdresp_data = {$urandom, $urandom};
        tick();
        bus.mem2slave_rdresp_vld = 1'b0;
        new_cmd(0);
        new_cmd(1);
        tick();
        checks++;
        if (grant_log.size() != 1 || grant_log[0] != 0) begin
            errors++;
            $display("FAIL midreset_first_grant got grants=%0d exp=single grant to req0", grant_log.size());
        end
        repeat (4) tick();
    endtask

    task automatic test_random();
        do_reset();
        on_ack  = 3;
        len_max = 3;
        for (int n = 0; n < 600; n++) begin
            bus.mem2slave_rd_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NR; i++) begin
                if (!r_req[i] && $urandom_range(0, 2) == 0) new_cmd(i);
            end
            bus.mem2slave_rdresp_vld  = (m_q.size() != 0) && ($urandom_range(0, 2) != 0);
            bus.mem2slave_rdresp_data = {$urandom, $urandom};
            tick();
        end
        bus.mem2slave_rdresp_vld = 1'b0;
        checks++;
        if (grant_log.size() < 20) begin
            errors++;
            $display("FAIL random_activity got grants=%0d exp>=20", grant_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_full_fifo();
        test_orphan();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
